// File: rtl/map_scroll_fetch.sv
// map_scroll_fetch: turns DTG screen coordinates into scrolled world coordinates, addresses the tile
// map and aligns coordinates with the map data. Build option SCROLL_WRAP_EN selects an endless map.
module map_scroll_fetch #(
    parameter int MAP_COLS_LOG2 = 7,
    parameter int MAP_ROWS_LOG2 = 7,
    parameter int TILE_LOG2     = 3,
    parameter int MEM_LATENCY   = 1,
    parameter int H_VISIBLE     = 640,
    localparam int SW = MAP_COLS_LOG2 + TILE_LOG2,
    localparam int AW = MAP_ROWS_LOG2 + MAP_COLS_LOG2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [11:0]   pixel_row,
    input  logic [11:0]   pixel_column,
    input  logic          video_on,
    input  logic          frame_start,
    input  logic          scroll_en,
    input  logic [3:0]    scroll_step,
    input  logic          scroll_load,
    input  logic [SW-1:0] scroll_value,
    output logic [AW-1:0] map_addr,
    input  logic [1:0]    map_data,
    output logic [1:0]    map_value,
    output logic [11:0]   world_row,
    output logic [11:0]   world_column,
    output logic          out_of_map,
    output logic [SW-1:0] scroll_x,
    output logic          scroll_end
);

    localparam int ROW_LIMIT = 1 << (MAP_ROWS_LOG2 + TILE_LOG2);
`ifndef SCROLL_WRAP_EN
    localparam logic [SW-1:0] SMAX = SW'((1 << SW) - H_VISIBLE);
`endif

    logic [SW-1:0] load_val;
    logic          load_pend;
    logic [SW-1:0] scroll_next;
    logic [SW-1:0] wcol;
    logic          oom;

    logic [11:0]   row_p0;
    logic [SW-1:0] wcol_p0;
    logic          oom_p0;
    logic [11:0]   row_dly  [MEM_LATENCY];
    logic [SW-1:0] wcol_dly [MEM_LATENCY];
    logic          oom_dly  [MEM_LATENCY];

`ifdef SCROLL_WRAP_EN
    function automatic logic [SW-1:0] scroll_advance(input logic [SW-1:0] x, input logic [3:0] step);
        return x + {{(SW-4){1'b0}}, step};
    endfunction

    function automatic logic [SW-1:0] load_clamp(input logic [SW-1:0] v);
        return v;
    endfunction
`else
    function automatic logic [SW-1:0] scroll_advance(input logic [SW-1:0] x, input logic [3:0] step);
        logic [SW:0] sum;
        sum = {1'b0, x} + {{(SW-3){1'b0}}, step};
        return (sum >= {1'b0, SMAX}) ? SMAX : sum[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] load_clamp(input logic [SW-1:0] v);
        return (v > SMAX) ? SMAX : v;
    endfunction
`endif

    // A pending load takes priority over the advance and suppresses it for that frame.
    always_comb begin
        scroll_next = scroll_x;
        if (frame_start) begin
            if (load_pend) begin
                scroll_next = load_clamp(load_val);
            end else if (scroll_en) begin
                scroll_next = scroll_advance(scroll_x, scroll_step);
            end
        end
    end

    // A load arriving together with frame_start stays pending for the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scroll_x  <= '0;
            load_val  <= '0;
            load_pend <= 1'b0;
        end else begin
            scroll_x <= scroll_next;
            if (scroll_load) begin
                load_val  <= scroll_value;
                load_pend <= 1'b1;
            end else if (frame_start) begin
                load_pend <= 1'b0;
            end
        end
    end

`ifdef SCROLL_WRAP_EN
    assign scroll_end = 1'b0;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scroll_end <= 1'b0;
        end else begin
            scroll_end <= (scroll_next == SMAX);
        end
    end
`endif

    assign wcol = pixel_column[SW-1:0] + scroll_x;
    assign oom  = !video_on || (32'(pixel_row) >= ROW_LIMIT) || (32'(pixel_column) >= H_VISIBLE);

    // Stage p0: address the map and capture the coordinates that go with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_addr <= '0;
            row_p0   <= '0;
            wcol_p0  <= '0;
            oom_p0   <= 1'b1;
        end else begin
            map_addr <= {pixel_row[TILE_LOG2 +: MAP_ROWS_LOG2], wcol[TILE_LOG2 +: MAP_COLS_LOG2]};
            row_p0   <= pixel_row;
            wcol_p0  <= wcol;
            oom_p0   <= oom;
        end
    end

    // Delay stages: the last stage lands with map_data sampled MEM_LATENCY clocks after map_addr.
    // Empty stages read as out-of-map so nothing stale looks drawable after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_value <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                row_dly[i]  <= '0;
                wcol_dly[i] <= '0;
                oom_dly[i]  <= 1'b1;
            end
        end else begin
            map_value   <= map_data;
            row_dly[0]  <= row_p0;
            wcol_dly[0] <= wcol_p0;
            oom_dly[0]  <= oom_p0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                row_dly[i]  <= row_dly[i-1];
                wcol_dly[i] <= wcol_dly[i-1];
                oom_dly[i]  <= oom_dly[i-1];
            end
        end
    end

    assign world_row    = row_dly[MEM_LATENCY-1];
    assign world_column = 12'(wcol_dly[MEM_LATENCY-1]);
    assign out_of_map   = oom_dly[MEM_LATENCY-1];

endmodule

// File: tb/tb_map_scroll_fetch.sv
// Bench for map_scroll_fetch: two instances (memory latency 1 and 3) share stimulus and are
// checked every cycle against a behavioural scroll/pipeline model plus hand-computed literals.
module tb_map_scroll_fetch;
    localparam int SW   = 10;
    localparam int AW   = 14;
    localparam int SMAX = 384;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [11:0] pixel_row = '0;
    logic [11:0] pixel_column = '0;
    logic video_on = 1'b0, frame_start = 1'b0, scroll_en = 1'b0, scroll_load = 1'b0;
    logic [3:0] scroll_step = '0;
    logic [SW-1:0] scroll_value = '0;

    logic [AW-1:0] addr1, addr3, a3_q1, a3_q2;
    logic [1:0]    data1, data3, mv1, mv3;
    logic [11:0]   wr1, wc1, wr3, wc3;
    logic          oom1, oom3, end1, end3;
    logic [SW-1:0] sx1, sx3;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Map memories whose data is tile_col[1:0]; the latency-3 one has two internal registers.
    assign data1 = addr1[1:0];
    always @(posedge clk) begin
        a3_q1 <= addr3;
        a3_q2 <= a3_q1;
    end
    assign data3 = a3_q2[1:0];

    map_scroll_fetch #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_start(frame_start), .scroll_en(scroll_en),
        .scroll_step(scroll_step), .scroll_load(scroll_load), .scroll_value(scroll_value),
        .map_addr(addr1), .map_data(data1), .map_value(mv1), .world_row(wr1),
        .world_column(wc1), .out_of_map(oom1), .scroll_x(sx1), .scroll_end(end1));

    map_scroll_fetch #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_start(frame_start), .scroll_en(scroll_en),
        .scroll_step(scroll_step), .scroll_load(scroll_load), .scroll_value(scroll_value),
        .map_addr(addr3), .map_data(data3), .map_value(mv3), .world_row(wr3),
        .world_column(wc3), .out_of_map(oom3), .scroll_x(sx3), .scroll_end(end3));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int n = 0;
    int s_x = 0, lv = 0;
    bit pend = 0;
    int h_row [8];
    int h_col [8];
    int h_spre[8];
    bit h_vid [8];

    function automatic int adv(input int x, input int step);
`ifdef SCROLL_WRAP_EN
        return (x + step) % 1024;
`else
        return (x + step > SMAX) ? SMAX : x + step;
`endif
    endfunction

    function automatic int clampv(input int v);
`ifdef SCROLL_WRAP_EN
        return v;
`else
        return (v > SMAX) ? SMAX : v;
`endif
    endfunction

    function automatic int exp_end(input int s);
`ifdef SCROLL_WRAP_EN
        return 0;
`else
        return (s == SMAX) ? 1 : 0;
`endif
    endfunction

    function automatic int wcol_of(input int k);
        return (h_col[k] + h_spre[k]) % 1024;
    endfunction

    function automatic int oom_of(input int k);
        return (!h_vid[k] || h_row[k] >= 1024 || h_col[k] >= 640) ? 1 : 0;
    endfunction

    function automatic int addr_of(input int k);
        return ((h_row[k] / 8) % 128) * 128 + (wcol_of(k) / 8) % 128;
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            n = 0; s_x = 0; lv = 0; pend = 0;
        end else if (clk) begin
            n = n + 1;
            h_row[n % 8]  = int'(pixel_row);
            h_col[n % 8]  = int'(pixel_column);
            h_vid[n % 8]  = video_on;
            h_spre[n % 8] = s_x;
            if (frame_start) begin
                if (pend) begin
                    s_x = clampv(lv);
                    pend = 0;
                end else if (scroll_en) begin
                    s_x = adv(s_x, int'(scroll_step));
                end
            end
            if (scroll_load) begin
                lv = int'(scroll_value);
                pend = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            check("rst map_addr", int'(addr1) + int'(addr3), 0);
            check("rst map_value", int'(mv1) + int'(mv3), 0);
            check("rst world_row", int'(wr1) + int'(wr3), 0);
            check("rst world_column", int'(wc1) + int'(wc3), 0);
            check("rst out_of_map", int'(oom1) + int'(oom3), 2);
            check("rst scroll_x", int'(sx1) + int'(sx3), 0);
            check("rst scroll_end", int'(end1) + int'(end3), 0);
        end else begin
            check("scroll_x L1", int'(sx1), s_x);
            check("scroll_x L3", int'(sx3), s_x);
            check("scroll_end L1", int'(end1), exp_end(s_x));
            check("scroll_end L3", int'(end3), exp_end(s_x));
            if (n >= 1) begin
                check("map_addr L1", int'(addr1), addr_of(n % 8));
                check("map_addr L3", int'(addr3), addr_of(n % 8));
            end
            if (n > 1) begin
                check("world_row L1", int'(wr1), h_row[(n - 1) % 8]);
                check("world_column L1", int'(wc1), wcol_of((n - 1) % 8));
                check("out_of_map L1", int'(oom1), oom_of((n - 1) % 8));
                check("map_value L1", int'(mv1), (wcol_of((n - 1) % 8) / 8) % 4);
            end
            if (n > 3) begin
                check("world_row L3", int'(wr3), h_row[(n - 3) % 8]);
                check("world_column L3", int'(wc3), wcol_of((n - 3) % 8));
                check("out_of_map L3", int'(oom3), oom_of((n - 3) % 8));
                check("map_value L3", int'(mv3), (wcol_of((n - 3) % 8) / 8) % 4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic load(input int v);
        scroll_value = SW'(v);
        scroll_load = 1'b1;
        tick();
        scroll_load = 1'b0;
    endtask

    task automatic set_pixel(input int r, input int c, input bit v);
        pixel_row = 12'(r);
        pixel_column = 12'(c);
        video_on = v;
    endtask

    task automatic random_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            set_pixel(int'($urandom_range(0, 1100)), int'($urandom_range(0, 760)),
                      $urandom_range(0, 9) != 0);
            frame_start  = ($urandom_range(0, 19) == 0);
            scroll_en    = $urandom_range(0, 1) == 1;
            scroll_step  = 4'($urandom_range(0, 15));
            scroll_load  = ($urandom_range(0, 29) == 0);
            scroll_value = SW'($urandom_range(0, 1023));
            tick();
        end
        frame_start = 1'b0;
        scroll_load = 1'b0;
        scroll_en = 1'b0;
    endtask

    initial begin
        ticks(3);
        check("lit rst out_of_map", int'(oom1), 1);
        reset_n = 1'b1;

        // Pixel (9,17) with scroll 0: tile (1,2).
        set_pixel(9, 17, 1'b1);
        tick();
        check("lit map_addr 0x82", int'(addr1), 'h82);
        tick();
        check("lit world_column 17", int'(wc1), 17);
        check("lit map_value 2", int'(mv1), 2);
        check("lit out_of_map 0", int'(oom1), 0);

        // Three advances of 5, holding between pulses.
        scroll_en = 1'b1;
        scroll_step = 4'd5;
        for (int i = 0; i < 3; i++) begin
            frame();
            ticks(3);
        end
        check("lit scroll 15", int'(sx1), 15);
        set_pixel(9, 0, 1'b1);
        ticks(2);
        check("lit world_column 15", int'(wc1), 15);

        // Load beats the advance in its frame.
        scroll_en = 1'b0;
        load(100);
        scroll_en = 1'b1;
        scroll_step = 4'd4;
        frame();
        check("lit load 100", int'(sx1), 100);
        tick();
        frame();
        check("lit advance 104", int'(sx1), 104);
        scroll_en = 1'b0;

        // Last load wins; a load on the frame_start cycle waits one frame.
        load(50);
        load(60);
        frame();
        check("lit last load 60", int'(sx1), 60);
        scroll_value = SW'(70);
        scroll_load = 1'b1;
        frame();
        scroll_load = 1'b0;
        check("lit same-cycle load held", int'(sx1), 60);
        tick();
        frame();
        check("lit deferred load 70", int'(sx1), 70);

`ifdef SCROLL_WRAP_EN
        load(1020);
        frame();
        set_pixel(20, 10, 1'b1);
        ticks(2);
        check("lit wrap world_column 6", int'(wc1), 6);
        scroll_en = 1'b1;
        scroll_step = 4'd8;
        frame();
        check("lit wrap scroll 4", int'(sx1), 4);
        check("lit wrap scroll_end 0", int'(end1), 0);
        scroll_en = 1'b0;
`else
        load(380);
        frame();
        check("lit scroll 380", int'(sx1), 380);
        check("lit scroll_end 0", int'(end1), 0);
        scroll_en = 1'b1;
        scroll_step = 4'd8;
        frame();
        check("lit saturate 384", int'(sx1), 384);
        check("lit scroll_end 1", int'(end1), 1);
        frame();
        check("lit stays 384", int'(sx1), 384);
        scroll_en = 1'b0;
        load(1000);
        frame();
        check("lit load clamps 384", int'(sx1), 384);
        load(10);
        frame();
        check("lit scroll_end clears", int'(end1), 0);
`endif

        // Out-of-map conditions, both latencies.
        set_pixel(1024, 5, 1'b1);
        ticks(2);
        check("lit oom row L1", int'(oom1), 1);
        ticks(2);
        check("lit oom row L3", int'(oom3), 1);
        set_pixel(5, 5, 1'b1);
        ticks(4);
        check("lit in map L3", int'(oom3), 0);
        set_pixel(5, 700, 1'b1);
        ticks(2);
        set_pixel(5, 5, 1'b0);
        ticks(4);

        random_cycles(1500);

        // Mid-cycle asynchronous reset, then refill.
        set_pixel(40, 300, 1'b1);
        ticks(4);
        #1;
        reset_n = 1'b0;
        #1;
        check("lit async rst out_of_map", int'(oom3), 1);
        check("lit async rst map_value", int'(mv1), 0);
        check("lit async rst world_column", int'(wc3), 0);
        ticks(2);
        reset_n = 1'b1;
        random_cycles(300);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
